// File: rtl/stamofu_req_arbiter.sv
// Arbitrates the store/AMO/fence address pipelines onto the shared dTLB/dcache request port.
// Misaligned-queue requests win over normal ones; each class keeps its own round-robin pointer.
module stamofu_req_arbiter #(
    parameter int unsigned REQUESTERS     = 2,
    parameter int unsigned LOG_REQUESTERS = $clog2(REQUESTERS),
    parameter int unsigned VPN_WIDTH      = 20,
    parameter int unsigned PO_WIDTH       = 12,
    parameter int unsigned CQ_INDEX_WIDTH = 4
) (
    input  logic                                         CLK,
    input  logic                                         RST,

    input  logic [REQUESTERS-1:0]                        req_valid,
    input  logic [REQUESTERS-1:0]                        req_is_mq,
    input  logic [REQUESTERS-1:0]                        req_misaligned,
    input  logic [REQUESTERS-1:0]                        req_misaligned_exception,
    input  logic [REQUESTERS-1:0][VPN_WIDTH-1:0]         req_VPN,
    input  logic [REQUESTERS-1:0][PO_WIDTH-3:0]          req_PO_word,
    input  logic [REQUESTERS-1:0][3:0]                   req_byte_mask,
    input  logic [REQUESTERS-1:0][31:0]                  req_write_data,
    input  logic [REQUESTERS-1:0][CQ_INDEX_WIDTH-1:0]    req_cq_index,
    output logic [REQUESTERS-1:0]                        req_ack,

    output logic                                         out_valid,
    output logic [LOG_REQUESTERS-1:0]                    out_src,
    output logic                                         out_is_mq,
    output logic                                         out_misaligned,
    output logic                                         out_misaligned_exception,
    output logic [VPN_WIDTH-1:0]                         out_VPN,
    output logic [PO_WIDTH-3:0]                          out_PO_word,
    output logic [3:0]                                   out_byte_mask,
    output logic [31:0]                                  out_write_data,
    output logic [CQ_INDEX_WIDTH-1:0]                    out_cq_index,
    input  logic                                         out_ready
);

    logic [LOG_REQUESTERS-1:0] rr_ptr_mq;
    logic [LOG_REQUESTERS-1:0] rr_ptr_norm;

    logic [REQUESTERS-1:0]     mq_valid;
    logic                      any_mq;
    logic [REQUESTERS-1:0]     eligible;
    logic [LOG_REQUESTERS-1:0] ptr;
    logic [LOG_REQUESTERS-1:0] idx;
    logic [LOG_REQUESTERS-1:0] winner;
    logic                      found;
    logic                      accept;
    logic                      grant;

    always_comb begin
        mq_valid = req_valid & req_is_mq;
        any_mq   = |mq_valid;
        eligible = any_mq ? mq_valid : req_valid;
        ptr      = any_mq ? rr_ptr_mq : rr_ptr_norm;

        // REQUESTERS is a power of two, so the index add wraps for free.
        idx    = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(REQUESTERS); i++) begin
            idx = ptr + LOG_REQUESTERS'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end

        accept  = ~out_valid | out_ready;
        grant   = accept & found & ~RST;
        req_ack = '0;
        if (grant) begin
            req_ack[winner] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid                <= 1'b0;
            out_src                  <= '0;
            out_is_mq                <= 1'b0;
            out_misaligned           <= 1'b0;
            out_misaligned_exception <= 1'b0;
            out_VPN                  <= '0;
            out_PO_word              <= '0;
            out_byte_mask            <= '0;
            out_write_data           <= '0;
            out_cq_index             <= '0;
            rr_ptr_mq                <= '0;
            rr_ptr_norm              <= '0;
        end else if (grant) begin
            out_valid                <= 1'b1;
            out_src                  <= winner;
            out_is_mq                <= req_is_mq[winner];
            out_misaligned           <= req_misaligned[winner];
            out_misaligned_exception <= req_misaligned_exception[winner];
            out_VPN                  <= req_VPN[winner];
            out_PO_word              <= req_PO_word[winner];
            out_byte_mask            <= req_byte_mask[winner];
            out_write_data           <= req_write_data[winner];
            out_cq_index             <= req_cq_index[winner];
            if (any_mq) begin
                rr_ptr_mq <= winner + LOG_REQUESTERS'(1);
            end else begin
                rr_ptr_norm <= winner + LOG_REQUESTERS'(1);
            end
        end else if (out_ready) begin
            // Drain: data fields deliberately hold their last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stamofu_req_arbiter.sv
// Directed and randomized checks of stamofu_req_arbiter against a behavioural model
// that tracks the held request and the two round-robin pointers as plain integers.
module tb_stamofu_req_arbiter;

    localparam int R   = 2;
    localparam int LR  = 1;
    localparam int VW  = 20;
    localparam int POW = 12;
    localparam int CQW = 4;
    localparam int BW  = 3 + VW + (POW - 2) + 4 + 32 + CQW;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [R-1:0]               req_valid;
    logic [R-1:0]               req_is_mq;
    logic [R-1:0]               req_misaligned;
    logic [R-1:0]               req_misaligned_exception;
    logic [R-1:0][VW-1:0]       req_VPN;
    logic [R-1:0][POW-3:0]      req_PO_word;
    logic [R-1:0][3:0]          req_byte_mask;
    logic [R-1:0][31:0]         req_write_data;
    logic [R-1:0][CQW-1:0]      req_cq_index;
    logic [R-1:0]               req_ack;
    logic                       out_valid;
    logic [LR-1:0]              out_src;
    logic                       out_is_mq;
    logic                       out_misaligned;
    logic                       out_misaligned_exception;
    logic [VW-1:0]              out_VPN;
    logic [POW-3:0]             out_PO_word;
    logic [3:0]                 out_byte_mask;
    logic [31:0]                out_write_data;
    logic [CQW-1:0]             out_cq_index;
    logic                       out_ready;

    stamofu_req_arbiter #(
        .REQUESTERS     (R),
        .LOG_REQUESTERS (LR),
        .VPN_WIDTH      (VW),
        .PO_WIDTH       (POW),
        .CQ_INDEX_WIDTH (CQW)
    ) dut (
        .CLK                      (CLK),
        .RST                      (RST),
        .req_valid                (req_valid),
        .req_is_mq                (req_is_mq),
        .req_misaligned           (req_misaligned),
        .req_misaligned_exception (req_misaligned_exception),
        .req_VPN                  (req_VPN),
        .req_PO_word              (req_PO_word),
        .req_byte_mask            (req_byte_mask),
        .req_write_data           (req_write_data),
        .req_cq_index             (req_cq_index),
        .req_ack                  (req_ack),
        .out_valid                (out_valid),
        .out_src                  (out_src),
        .out_is_mq                (out_is_mq),
        .out_misaligned           (out_misaligned),
        .out_misaligned_exception (out_misaligned_exception),
        .out_VPN                  (out_VPN),
        .out_PO_word              (out_PO_word),
        .out_byte_mask            (out_byte_mask),
        .out_write_data           (out_write_data),
        .out_cq_index             (out_cq_index),
        .out_ready                (out_ready)
    );

    logic [BW-1:0] got_bundle;
    assign got_bundle = {out_is_mq, out_misaligned, out_misaligned_exception, out_VPN,
                         out_PO_word, out_byte_mask, out_write_data, out_cq_index};

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_valid   = 1'b0;
    int            m_src     = 0;
    logic [BW-1:0] m_bundle  = '0;
    int            m_rr_mq   = 0;
    int            m_rr_norm = 0;

    function automatic logic [R-1:0] model_ack();
        logic [R-1:0] r;
        bit any_mq;
        int ptr;
        int j;
        r = '0;
        any_mq = 1'b0;
        if (RST || (m_valid && !out_ready)) return r;
        for (int k = 0; k < R; k++) begin
            if (req_valid[k] && req_is_mq[k]) any_mq = 1'b1;
        end
        ptr = any_mq ? m_rr_mq : m_rr_norm;
        for (int k = 0; k < R; k++) begin
            j = (ptr + k) % R;
            if (req_valid[j] && (!any_mq || req_is_mq[j])) begin
                r[j] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Advance one clock and update the model; returns at the following negedge.
    task automatic tick();
        logic [R-1:0] a;
        int j;
        a = model_ack();
        @(posedge CLK);
        if (RST) begin
            m_valid   = 1'b0;
            m_src     = 0;
            m_bundle  = '0;
            m_rr_mq   = 0;
            m_rr_norm = 0;
        end else if (a != '0) begin
            j = 0;
            for (int k = 0; k < R; k++) if (a[k]) j = k;
            m_valid  = 1'b1;
            m_src    = j;
            m_bundle = {req_is_mq[j], req_misaligned[j], req_misaligned_exception[j], req_VPN[j],
                        req_PO_word[j], req_byte_mask[j], req_write_data[j], req_cq_index[j]};
            if (req_is_mq[j]) m_rr_mq = (j + 1) % R;
            else              m_rr_norm = (j + 1) % R;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge CLK);
    endtask

    task automatic set_req(input int k, input logic [VW-1:0] vpn, input logic [POW-3:0] po,
                           input logic [3:0] mask, input logic [31:0] data,
                           input logic [CQW-1:0] cq, input logic mq);
        req_VPN[k]        = vpn;
        req_PO_word[k]    = po;
        req_byte_mask[k]  = mask;
        req_write_data[k] = data;
        req_cq_index[k]   = cq;
        req_is_mq[k]      = mq;
        req_misaligned[k] = 1'b0;
        req_misaligned_exception[k] = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        out_ready = 1'b1;
        req_valid = 2'b11;
        set_req(0, 20'h11111, 10'h1, 4'h1, 32'h1, 4'h1, 1'b0);
        set_req(1, 20'h22222, 10'h2, 4'h2, 32'h2, 4'h2, 1'b0);
        #1;
        if (req_ack !== 2'b00) begin
            errors++; $display("FAIL reset_ack: got %b want 00", req_ack);
        end
        checks++;
        tick();
        tick();
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_src !== '0 || got_bundle !== '0) begin
            errors++; $display("FAIL reset_fields: src %h bundle %h want all zero", out_src, got_bundle);
        end
        checks++;
        RST = 1'b0;
        #1;
        if (req_ack !== 2'b01) begin
            errors++; $display("FAIL reset_first_ack: got %b want 01", req_ack);
        end
        checks++;
        tick();
        if (out_valid !== 1'b1 || out_src !== 1'b0) begin
            errors++; $display("FAIL reset_first_out: valid %b src %0d want 1/0", out_valid, out_src);
        end
        checks++;
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_single_and_drain();
        out_ready = 1'b1;
        req_valid = 2'b01;
        set_req(0, 20'hABCDE, 10'h3F, 4'b1111, 32'hDEADBEEF, 4'd5, 1'b0);
        #1;
        if (req_ack !== 2'b01) begin
            errors++; $display("FAIL single_ack: got %b want 01", req_ack);
        end
        checks++;
        tick();
        if (out_valid !== 1'b1 || out_src !== 1'b0) begin
            errors++; $display("FAIL single_out: valid %b src %0d want 1/0", out_valid, out_src);
        end
        checks++;
        if (out_VPN !== 20'hABCDE || out_PO_word !== 10'h3F || out_byte_mask !== 4'hF ||
            out_write_data !== 32'hDEADBEEF || out_cq_index !== 4'd5 || out_is_mq !== 1'b0) begin
            errors++; $display("FAIL single_fields: got %h want echoed request", got_bundle);
        end
        checks++;
        req_valid = 2'b00;
        tick();
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_valid: got %b want 0", out_valid);
        end
        checks++;
        if (out_VPN !== 20'hABCDE || out_write_data !== 32'hDEADBEEF || out_cq_index !== 4'd5) begin
            errors++; $display("FAIL drain_hold: got %h want fields held", got_bundle);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        logic [R-1:0] want;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        out_ready = 1'b1;
        req_valid = 2'b11;
        set_req(0, 20'h00A00, 10'h10, 4'h3, 32'hA0A0A0A0, 4'd1, 1'b0);
        set_req(1, 20'h00B00, 10'h20, 4'hC, 32'hB0B0B0B0, 4'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            if (req_ack !== want) begin
                errors++; $display("FAIL rr_ack step %0d: got %b want %b", k, req_ack, want);
            end
            checks++;
            tick();
            if (out_valid !== 1'b1 || out_src !== LR'(k % 2)) begin
                errors++; $display("FAIL rr_src step %0d: valid %b src %0d want 1/%0d",
                                   k, out_valid, out_src, k % 2);
            end
            checks++;
        end
    endtask

    // Entry state: rr_norm=0, rr_mq=0.
    task automatic test_mq_priority();
        out_ready = 1'b1;
        req_valid = 2'b11;
        req_is_mq = 2'b10;
        #1;
        if (req_ack !== 2'b10) begin
            errors++; $display("FAIL mq_win: got %b want 10", req_ack);
        end
        checks++;
        tick();
        if (out_src !== 1'b1 || out_is_mq !== 1'b1) begin
            errors++; $display("FAIL mq_out: src %0d is_mq %b want 1/1", out_src, out_is_mq);
        end
        checks++;
        req_valid = 2'b01;
        req_is_mq = 2'b00;
        #1;
        if (req_ack !== 2'b01) begin
            errors++; $display("FAIL mq_then_norm: got %b want 01", req_ack);
        end
        checks++;
        tick();
        req_valid = 2'b11;
        req_is_mq = 2'b11;
        #1;
        if (req_ack !== 2'b01) begin
            errors++; $display("FAIL mq_rr0: got %b want 01", req_ack);
        end
        checks++;
        tick();
        #1;
        if (req_ack !== 2'b10) begin
            errors++; $display("FAIL mq_rr1: got %b want 10", req_ack);
        end
        checks++;
        tick();
        // Normal pointer must still be where the lone normal grant left it.
        req_is_mq = 2'b00;
        #1;
        if (req_ack !== 2'b10) begin
            errors++; $display("FAIL norm_ptr_kept: got %b want 10", req_ack);
        end
        checks++;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        req_valid = 2'b01;
        set_req(0, 20'h0C0C0, 10'h33, 4'h5, 32'h12345678, 4'd3, 1'b0);
        set_req(1, 20'h0D0D0, 10'h44, 4'hA, 32'h87654321, 4'd9, 1'b0);
        tick();
        out_ready = 1'b0;
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (req_ack !== 2'b00) begin
                errors++; $display("FAIL stall_ack cycle %0d: got %b want 00", k, req_ack);
            end
            checks++;
            tick();
            if (out_valid !== 1'b1 || out_src !== 1'b0 || out_cq_index !== 4'd3) begin
                errors++; $display("FAIL stall_hold cycle %0d: valid %b src %0d cq %0d want 1/0/3",
                                   k, out_valid, out_src, out_cq_index);
            end
            checks++;
        end
        out_ready = 1'b1;
        #1;
        if (req_ack !== 2'b10) begin
            errors++; $display("FAIL unstall_ack: got %b want 10", req_ack);
        end
        checks++;
        tick();
        if (out_src !== 1'b1 || out_cq_index !== 4'd9) begin
            errors++; $display("FAIL unstall_out: src %0d cq %0d want 1/9", out_src, out_cq_index);
        end
        checks++;
        out_ready = 1'b0;
        req_valid = 2'b11;
        RST = 1'b1;
        #1;
        if (req_ack !== 2'b00) begin
            errors++; $display("FAIL midreset_ack: got %b want 00", req_ack);
        end
        checks++;
        tick();
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_drop: got %b want 0", out_valid);
        end
        checks++;
        RST = 1'b0;
    endtask

    task automatic test_random();
        logic [R-1:0] want;
        for (int c = 0; c < 3000; c++) begin
            RST       = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            req_valid = R'($urandom);
            req_is_mq = R'($urandom & $urandom);
            for (int k = 0; k < R; k++) begin
                req_VPN[k]                  = VW'($urandom);
                req_PO_word[k]              = (POW - 2)'($urandom);
                req_byte_mask[k]            = 4'($urandom);
                req_write_data[k]           = $urandom;
                req_cq_index[k]             = CQW'($urandom);
                req_misaligned[k]           = 1'($urandom);
                req_misaligned_exception[k] = 1'($urandom);
            end
            #1;
            want = model_ack();
            if (req_ack !== want) begin
                errors++; $display("FAIL rand_ack cycle %0d: got %b want %b", c, req_ack, want);
            end
            checks++;
            tick();
            if (out_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid cycle %0d: got %b want %b", c, out_valid, m_valid);
            end
            checks++;
            if (out_src !== LR'(m_src)) begin
                errors++; $display("FAIL rand_src cycle %0d: got %0d want %0d", c, out_src, m_src);
            end
            checks++;
            if (got_bundle !== m_bundle) begin
                errors++; $display("FAIL rand_fields cycle %0d: got %h want %h", c, got_bundle, m_bundle);
            end
            checks++;
        end
        RST = 1'b0;
    endtask

    initial begin
        req_valid = '0;
        req_is_mq = '0;
        req_misaligned = '0;
        req_misaligned_exception = '0;
        req_VPN = '0;
        req_PO_word = '0;
        req_byte_mask = '0;
        req_write_data = '0;
        req_cq_index = '0;
        out_ready = 1'b0;
        RST = 1'b1;
        test_reset();
        test_single_and_drain();
        test_round_robin();
        test_mq_priority();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stamofu_req_arbiter.md
Name: stamofu_req_arbiter

Overview:
- Shares the single dTLB/dcache request port between REQUESTERS store/AMO/fence address pipelines. Each pipeline presents a REQ-stage bundle.
- Each cycle the arbiter grants at most one requester. Misaligned-queue (mq) traffic has priority; round-robin applies within each class.
- The winner's bundle is captured into a one-entry output register that drives the shared port under a valid/ready handshake.
- The arbiter returns a per-requester ack, which is the REQ_ack input of the corresponding address pipeline.

Parameters:
REQUESTERS, 2, number of address pipelines sharing the port (power of 2, >=2)
LOG_REQUESTERS, 1, $clog2(REQUESTERS)
VPN_WIDTH, 20, virtual page number width
PO_WIDTH, 12, page offset width; PO_word is PO_WIDTH-2 bits
CQ_INDEX_WIDTH, 4, stamofu CQ index width

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
req_valid  in  REQUESTERS  per-requester REQ valid
req_is_mq  in  REQUESTERS  request originates from the misaligned queue
req_misaligned  in  REQUESTERS  access crosses a word boundary
req_misaligned_exception  in  REQUESTERS  misaligned AMO; exception only
req_VPN  in  REQUESTERS x VPN_WIDTH  virtual page number
req_PO_word  in  REQUESTERS x (PO_WIDTH-2)  word page offset
req_byte_mask  in  REQUESTERS x 4  byte enables
req_write_data  in  REQUESTERS x 32  store data
req_cq_index  in  REQUESTERS x CQ_INDEX_WIDTH  stamofu CQ index
req_ack  out  REQUESTERS  one-hot grant/ack back to the pipeline (REQ_ack)
out_valid  out  1  output register holds a request
out_src  out  LOG_REQUESTERS  requester index of the held request
out_is_mq, out_misaligned, out_misaligned_exception  out  1 each  held fields
out_VPN  out  VPN_WIDTH  held field
out_PO_word  out  PO_WIDTH-2  held field
out_byte_mask  out  4  held field
out_write_data  out  32  held field
out_cq_index  out  CQ_INDEX_WIDTH  held field
out_ready  in  1  downstream consumes the held request this cycle

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset (RST high at a posedge): out_valid=0, out_src=0, all out_* data fields=0, rr_ptr_mq=0, rr_ptr_norm=0.
- While RST is high, req_ack is forced to 0 combinationally.
- accept = ~out_valid | out_ready. This is combinational, and throughput is 1 request/cycle.
- Class select: if any req_valid&req_is_mq is set, only the mq requesters are eligible. Otherwise all req_valid requesters are eligible.
- Winner: the first eligible index scanning upward from the class pointer (rr_ptr_mq or rr_ptr_norm), wrapping mod REQUESTERS.
- req_ack[winner] = accept & eligible. All other acks are 0, so req_ack is always one-hot or zero. req_ack is combinational from req_valid, req_is_mq, out_valid and out_ready; it has no registered delay.
- On a grant, at the posedge:
  - out_* <= winner's fields, out_src <= winner, out_valid <= 1.
  - The pointer of the winning class <= winner+1 mod REQUESTERS. The other class pointer is unchanged.
- No grant but out_ready & out_valid: out_valid <= 0. Data fields hold their last values; they are don't-care, but the bench checks that they are held.
- No grant and ~out_ready: the output register holds (stall). req_ack=0 for all requesters, and each requester must keep its bundle stable.
- Latency: a request acked in cycle N appears on out_valid in cycle N+1.
- Back-to-back: out_ready=1 and a new grant in the same cycle replaces the entry with no bubble.
- Fields pass through unmodified. misaligned_exception requests are arbitrated identically to all others.
- Requester protocol: a requester that is not acked keeps req_valid high with a stable bundle. The arbiter does not check this.
- Reset mid-operation: the held request is dropped (out_valid=0). Pending requesters stay unacked until after reset.
- Starvation: round-robin guarantees that any normal requester is granted within REQUESTERS normal grants, but only while no mq traffic is present.

Test Plan:
1. Reset: RST=1 for 2 cycles with req_valid=2'b11 -> req_ack=00, out_valid=0, all out_* = 0. After release, req 0 is acked first (rr_ptr=0).
2. Single request: req0 valid, VPN=20'hABCDE, PO_word=10'h3F, byte_mask=4'b1111, write_data=32'hDEADBEEF, cq_index=5, out_ready=1 -> req_ack=01 that cycle. Next cycle: out_valid=1, out_src=0, all fields echoed.
3. Round-robin: both requesters valid continuously, out_ready=1 -> acks alternate 01,10,01,10. out_src alternates 0,1,0,1 one cycle later.
4. mq priority: req0 normal, req1 with is_mq=1, both valid, rr_ptr_norm=0 -> req1 acked. Next cycle with req1 deasserted -> req0 acked.
5. Backpressure: out_valid=1 (src0, cq_index=3), out_ready=0 for 3 cycles, req1 valid -> req_ack=00 and out_* stable for 3 cycles. out_ready=1 -> req1 acked the same cycle; next cycle out_src=1.
6. Drain: out_valid=1, out_ready=1, no req_valid -> next cycle out_valid=0, data fields unchanged.
